// File: rtl/i2c_txn_sequencer_if.sv
// -----------------------------------------------------------------------------
// i2c_txn_sequencer_if
// Groups the bus-condition strobes, the SDA pull-down, the write-byte handshake
// to the hash core and the hash read-back value used by i2c_txn_sequencer.
//   start_cond/stop_cond : one-cycle START/STOP pulses from the front end
//   scl_rise/scl_fall    : one-cycle synchronized SCL edge strobes
//   sda_in               : synchronized SDA level
//   sda_oe               : 1 = pull SDA low
//   wr_valid/wr_data/wr_ready : write byte handshake towards the hasher
//   hash_in              : current hash value, MSB byte is sent first
//   busy/overflow        : status
// Modport slave is the sequencer's view; master is the environment's view.
// -----------------------------------------------------------------------------
interface i2c_txn_sequencer_if #(
  parameter int HASH_BYTES = 4
);
  logic                    start_cond;
  logic                    stop_cond;
  logic                    scl_rise;
  logic                    scl_fall;
  logic                    sda_in;
  logic                    sda_oe;
  logic                    wr_valid;
  logic [7:0]              wr_data;
  logic                    wr_ready;
  logic [8*HASH_BYTES-1:0] hash_in;
  logic                    busy;
  logic                    overflow;

  modport slave (
    input  start_cond, stop_cond, scl_rise, scl_fall, sda_in, wr_ready, hash_in,
    output sda_oe, wr_valid, wr_data, busy, overflow
  );

  modport master (
    output start_cond, stop_cond, scl_rise, scl_fall, sda_in, wr_ready, hash_in,
    input  sda_oe, wr_valid, wr_data, busy, overflow
  );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_txn_sequencer
// Byte-level I2C target controller. Receives the address byte, ACKs a match,
// hands write bytes to the hash core through a one-byte valid/ready slot and
// shifts out a snapshot of the hash value (MSB byte first) on reads.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : i2c_txn_sequencer_if.slave (strobes, SDA, write handshake, status)
// All outputs are registered.
// -----------------------------------------------------------------------------
module i2c_txn_sequencer #(
  parameter logic [6:0] DEVICE_ADDR = 7'h2A,
  parameter int         HASH_BYTES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  i2c_txn_sequencer_if.slave   bus
);

  localparam int HW    = 8 * HASH_BYTES;
  localparam int IDX_W = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               rw_q, rw_d;
  logic               ack_ok_q, ack_ok_d;
  // Second-half flag: in ACK states "ACK already driven", in READ "all 8 bits driven".
  logic               phase_q, phase_d;
  logic [HW-1:0]      snap_q, snap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sda_oe_q, sda_oe_d;
  logic               wr_valid_q, wr_valid_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;

  logic [7:0]         shift_in_s;
  logic [7:0]         cur_byte_s;
  logic [IDX_W-1:0]   idx_next_s;

  // Byte k of the snapshot, counted from the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [HW-1:0] v, input logic [IDX_W-1:0] k);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < HASH_BYTES; i++) begin
      if (k == i[IDX_W-1:0]) r = v[8*(HASH_BYTES-1-i) +: 8];
    end
    return r;
  endfunction

  assign shift_in_s = {shift_q[6:0], bus.sda_in};
  assign cur_byte_s = byte_sel(snap_q, idx_q);
  assign idx_next_s = (idx_q == IDX_W'(HASH_BYTES - 1)) ? '0 : idx_q + IDX_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ack_ok_d   = ack_ok_q;
    phase_d    = phase_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = wr_valid_q;
    wr_data_d  = wr_data_q;
    overflow_d = overflow_q;

    // Pending byte leaves the slot only through the handshake, never via START/STOP.
    if (wr_valid_q && bus.wr_ready) wr_valid_d = 1'b0;
    else                            wr_valid_d = wr_valid_q;

    if (bus.start_cond) begin
      state_d    = S_ADDR;
      bit_cnt_d  = 3'd0;
      phase_d    = 1'b0;
      sda_oe_d   = 1'b0;
      overflow_d = 1'b0;
    end else if (bus.stop_cond) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (bus.scl_rise) begin
            shift_d   = shift_in_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_in_s[7:1] == DEVICE_ADDR) begin
                state_d = S_ADDR_ACK;
                rw_d    = shift_in_s[0];
                phase_d = 1'b0;
              end else begin
                state_d = S_IGNORE;
              end
            end else begin
              state_d = S_ADDR;
            end
          end else begin
            state_d = S_ADDR;
          end
        end
        S_ADDR_ACK: begin
          if (bus.scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else if (rw_q) begin
              // Snapshot now; bit 7 of byte 0 comes straight from hash_in this cycle.
              snap_d    = bus.hash_in;
              idx_d     = '0;
              sda_oe_d  = ~bus.hash_in[HW-1];
              bit_cnt_d = 3'd1;
              phase_d   = 1'b0;
              state_d   = S_READ;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              phase_d   = 1'b0;
              state_d   = S_WRITE;
            end
          end else begin
            state_d = S_ADDR_ACK;
          end
        end
        S_WRITE: begin
          if (bus.scl_rise) begin
            shift_d   = shift_in_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (!wr_valid_q) begin
                wr_data_d  = shift_in_s;
                wr_valid_d = 1'b1;
                ack_ok_d   = 1'b1;
              end else begin
                overflow_d = 1'b1;
                ack_ok_d   = 1'b0;
              end
              phase_d = 1'b0;
              state_d = S_WRITE_ACK;
            end else begin
              state_d = S_WRITE;
            end
          end else begin
            state_d = S_WRITE;
          end
        end
        S_WRITE_ACK: begin
          if (bus.scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = ack_ok_q;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = S_WRITE;
            end
          end else begin
            state_d = S_WRITE_ACK;
          end
        end
        S_READ: begin
          if (bus.scl_fall) begin
            if (phase_q) begin
              // Falling edge after bit 0: hand SDA to the master for its ACK.
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = S_READ_ACK;
            end else begin
              sda_oe_d  = ~cur_byte_s[3'd7 - bit_cnt_q];
              bit_cnt_d = bit_cnt_q + 3'd1;
              phase_d   = (bit_cnt_q == 3'd7);
            end
          end else begin
            state_d = S_READ;
          end
        end
        S_READ_ACK: begin
          if (bus.scl_rise) begin
            if (!bus.sda_in) begin
              idx_d     = idx_next_s;
              bit_cnt_d = 3'd0;
              phase_d   = 1'b0;
              state_d   = S_READ;
            end else begin
              state_d = S_IGNORE;
            end
          end else begin
            state_d = S_READ_ACK;
          end
        end
        S_IDLE, S_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_IGNORE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      ack_ok_q   <= 1'b0;
      phase_q    <= 1'b0;
      snap_q     <= '0;
      idx_q      <= '0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ack_ok_q   <= ack_ok_d;
      phase_q    <= phase_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

endmodule
